frame_pattern_gen: RTL and testbench
====================================

Name: frame_pattern_gen

Overview:
Parametrised per-pixel frame generator between the ALU and the TFT driver. The TFT driver requests a pixel by row and column; the block returns 24-bit RGB one cycle later. Four modes: timed solid-colour cycling (R→G→B), colour bars, checkerboard, and a vitals display that draws HR and SpO2 as horizontal bars. All frame content is computed on the fly, so no frame RAM is needed. Mode and vitals changes take effect only at frame boundaries, so frames never tear.

Parameters:
H_ACTIVE, 800, active columns per line
V_ACTIVE, 480, active rows per frame
COORD_W, 16, width of row/column coordinates
COLOR_W, 8, bits per colour channel
HOLD_FRAMES, 102, frames per solid colour before advancing (≥1)
DATA_W, 8, width of i_hr / i_spo2

Ports:
i_clk  in  1  system clock (50 MHz)
i_rst  in  1  reset, asynchronous, active-high
i_hr  in  DATA_W  heart rate from ALU, bpm
i_spo2  in  DATA_W  SpO2 from ALU, percent
i_alu_dv  in  1  one-cycle strobe, i_hr/i_spo2 valid
i_mode  in  2  requested mode: 0 solid cycle, 1 bars, 2 checker, 3 vitals
i_frame_start  in  1  one-cycle pulse from TFT driver before pixel (0,0) of each frame
i_pix_req  in  1  pixel request strobe
i_row_pixel  in  COORD_W  requested row
i_col_pixel  in  COORD_W  requested column
o_red  out  COLOR_W  red channel
o_green  out  COLOR_W  green channel
o_blue  out  COLOR_W  blue channel
o_pix_valid  out  1  RGB valid, i_pix_req delayed one cycle
o_color_idx  out  2  current solid colour: 0 R, 1 G, 2 B

Behaviour:
- Reset (async assert, synchronous release): o_red/o_green/o_blue = 0, o_pix_valid = 0, o_color_idx = 0, frame counter = 0, active mode = 0, shadow and active vitals = 0. A reset mid-frame aborts the frame. After release, output is solid red until the next i_frame_start.
- FULL means all ones on COLOR_W. ZERO means 0.
- Frame counter, on each i_frame_start:
  - If counter == HOLD_FRAMES-1: counter ← 0 and colour index advances 0→1→2→0.
  - Otherwise counter increments.
  - Index value 3 is never produced.
- Mode: i_mode is sampled only on i_frame_start. Changes mid-frame are ignored until the next frame.
- Vitals:
  - i_alu_dv loads i_hr/i_spo2 into shadow registers.
  - i_frame_start copies shadow to active.
  - If i_alu_dv and i_frame_start coincide, active takes the new i_hr/i_spo2 directly.
- Latency: exactly 1 cycle. o_* are registered and update on cycles where i_pix_req = 1. When i_pix_req = 0, RGB holds and o_pix_valid = 0. Back-to-back requests every cycle are supported.
- Out of range: col ≥ H_ACTIVE or row ≥ V_ACTIVE outputs black, with o_pix_valid still asserted.
- Mode 0 (solid cycle): whole frame is the current index colour (R = FULL,0,0; G = 0,FULL,0; B = 0,0,FULL).
- Mode 1 (colour bars): 8 vertical bars.
  - Bar k covers col in [k·H_ACTIVE/8, (k+1)·H_ACTIVE/8), using integer constants computed at elaboration; no runtime divider.
  - Colour: R = bit2 of (7−k), G = bit1, B = bit0, each bit expanded to FULL/ZERO. Bar 0 is white, bar 7 is black.
- Mode 2 (checkerboard): 32×32 tiles. If row[5] XOR col[5] = 1, the pixel is the current index colour; otherwise black.
- Mode 3 (vitals), background black:
  - HR bar: red, rows [V_ACTIVE/4, V_ACTIVE/4+40), cols < min(hr·4, H_ACTIVE).
  - SpO2 bar: blue, rows [V_ACTIVE/2, V_ACTIVE/2+40), cols < min(spo2·8, H_ACTIVE).
  - Products are computed at width DATA_W+3 with no overflow. The saturation compare uses COORD_W.
  - hr = 0 or spo2 = 0 draws no bar. spo2 ≥ 100 fills the full width.
- In modes 1–3, the frame counter and colour index still advance every HOLD_FRAMES frames.

Optional Feature:
FRAME_BORDER_EN:
- Defined: pixels with row==0, row==V_ACTIVE−1, col==0 or col==H_ACTIVE−1 are forced white (FULL,FULL,FULL) in every mode. This overrides the mode colour, keeps the same 1-cycle latency, and does not apply to out-of-range pixels.
- Undefined: no border logic is built and the mode colour is output unchanged.

Test Plan:
- Reset: assert i_rst mid-request → RGB = 0, o_pix_valid = 0 immediately. Release, request (10,10) → (FF,00,00) next cycle, o_color_idx = 0.
- Colour cycling (HOLD_FRAMES=2, mode 0): 2 frame_start pulses → idx = 1, pixel (0,5) = (00,FF,00). After 4 pulses → idx = 2, (00,00,FF). After 6 pulses → idx = 0, red.
- Mode 1, pixel requests every cycle for cols 0, 99, 100, 799 on row 0 → (FF,FF,FF), (FF,FF,FF), (FF,FF,00), (00,00,00), each with o_pix_valid 1 cycle after i_pix_req. Col 800 → black with valid = 1.
- Vitals: i_alu_dv with hr=60, spo2=98, then frame_start, mode 3.
  - (120,239) → red; (120,240) → black.
  - (240,783) → blue; (240,784) → black.
  - hr=255 → (120,799) red (saturated).
- Frame-boundary latching: change i_mode 0→2 and pulse i_alu_dv mid-frame → output unchanged until the next i_frame_start, then checker: (0,32) = colour, (32,32) = black. Coincident dv and frame_start with hr=50 → bar ends at col 199.
- FRAME_BORDER_EN defined, mode 3 → (0,400) and (479,0) = (FF,FF,FF); undefined → (00,00,00).

Source files
------------

// File: rtl/frame_pattern_gen_if.sv
// frame_pattern_gen_if
// Bundles the pixel request/response signals and the ALU vitals feed of
// frame_pattern_gen.
//   master : the TFT driver / ALU side. It drives the i_* signals and
//            receives the o_* signals.
//   slave  : the pattern generator itself.
// Signals:
//   i_hr, i_spo2   vitals values from the ALU, valid when i_alu_dv is high
//   i_alu_dv       one-cycle strobe that qualifies i_hr/i_spo2
//   i_mode         requested display mode, used at the next frame start
//   i_frame_start  pulse sent before pixel (0,0) of each frame
//   i_pix_req      pixel request strobe, with i_row_pixel/i_col_pixel
//   o_red/green/blue  registered RGB, returned one cycle after a request
//   o_pix_valid    high one cycle after i_pix_req
//   o_color_idx    current solid-colour index (0 R, 1 G, 2 B)
interface frame_pattern_gen_if #(
  parameter int COORD_W = 16,
  parameter int COLOR_W = 8,
  parameter int DATA_W  = 8
);
  logic [DATA_W-1:0]  i_hr;
  logic [DATA_W-1:0]  i_spo2;
  logic               i_alu_dv;
  logic [1:0]         i_mode;
  logic               i_frame_start;
  logic               i_pix_req;
  logic [COORD_W-1:0] i_row_pixel;
  logic [COORD_W-1:0] i_col_pixel;
  logic [COLOR_W-1:0] o_red;
  logic [COLOR_W-1:0] o_green;
  logic [COLOR_W-1:0] o_blue;
  logic               o_pix_valid;
  logic [1:0]         o_color_idx;

  modport master (
    output i_hr, i_spo2, i_alu_dv, i_mode, i_frame_start,
           i_pix_req, i_row_pixel, i_col_pixel,
    input  o_red, o_green, o_blue, o_pix_valid, o_color_idx
  );

  modport slave (
    input  i_hr, i_spo2, i_alu_dv, i_mode, i_frame_start,
           i_pix_req, i_row_pixel, i_col_pixel,
    output o_red, o_green, o_blue, o_pix_valid, o_color_idx
  );
endinterface

// File: rtl/frame_pattern_gen.sv
// frame_pattern_gen
// Generates pixel colours on demand for the TFT driver. No frame store is
// needed because every pixel is computed from its row and column. There
// are four modes: solid colour cycling, colour bars, a checkerboard, and a
// vitals display with HR and SpO2 drawn as bars. The mode and the vitals
// change only at frame boundaries.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    frame_pattern_gen_if.slave. Carries the pixel request and
//          response and the ALU vitals feed.
// Build option:
//   FRAME_BORDER_EN  when defined, the outermost in-range pixels are
//                    forced to white in every mode.
module frame_pattern_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int COORD_W     = 16,
  parameter int COLOR_W     = 8,
  parameter int HOLD_FRAMES = 102,
  parameter int DATA_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  frame_pattern_gen_if.slave bus
);
  localparam int CNT_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int PROD_W = DATA_W + 3;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [COORD_W-1:0] H_MAX    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_MAX    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HR_TOP   = COORD_W'(V_ACTIVE / 4);
  localparam logic [COORD_W-1:0] HR_BOT   = COORD_W'(V_ACTIVE / 4 + 40);
  localparam logic [COORD_W-1:0] SP_TOP   = COORD_W'(V_ACTIVE / 2);
  localparam logic [COORD_W-1:0] SP_BOT   = COORD_W'(V_ACTIVE / 2 + 40);

  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [1:0]         color_idx_q, color_idx_d;
  logic [1:0]         mode_q, mode_d;
  logic [DATA_W-1:0]  hr_sh_q, hr_sh_d, spo2_sh_q, spo2_sh_d;
  logic [DATA_W-1:0]  hr_q, hr_d, spo2_q, spo2_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               pix_valid_q;

  logic [COORD_W-1:0] row, col;
  // Every mode produces only FULL/ZERO per channel, so a pixel is carried
  // as one bit per channel {r,g,b} and widened at the output register.
  logic [2:0]         idx_rgb, bar_rgb, pix_rgb;
  logic [2:0]         bar_k;
  logic [PROD_W-1:0]  hr_prod, spo2_prod;
  logic [COORD_W-1:0] hr_len, spo2_len;
  logic               in_range, hr_hit, spo2_hit;

  assign row = bus.i_row_pixel;
  assign col = bus.i_col_pixel;

  // Frame-boundary state: the counter, the colour index, the mode and the
  // vitals. The shadow registers follow the ALU strobe. The active copy
  // changes only at frame start, so a frame is never drawn with a mix of
  // old and new values.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    color_idx_d = color_idx_q;
    mode_d      = mode_q;
    hr_sh_d     = hr_sh_q;
    spo2_sh_d   = spo2_sh_q;
    hr_d        = hr_q;
    spo2_d      = spo2_q;
    if (bus.i_alu_dv) begin
      hr_sh_d   = bus.i_hr;
      spo2_sh_d = bus.i_spo2;
    end
    if (bus.i_frame_start) begin
      mode_d = bus.i_mode;
      hr_d   = bus.i_alu_dv ? bus.i_hr   : hr_sh_q;
      spo2_d = bus.i_alu_dv ? bus.i_spo2 : spo2_sh_q;
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        color_idx_d = (color_idx_q == 2'd2) ? 2'd0 : color_idx_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    unique case (color_idx_q)
      2'd0:    idx_rgb = 3'b100;
      2'd1:    idx_rgb = 3'b010;
      2'd2:    idx_rgb = 3'b001;
      default: idx_rgb = 3'b000;
    endcase

    // The bar index is the count of bar edges at or left of this column.
    // The edge positions are constants, so no divider is built.
    bar_k = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (col >= COORD_W'((b * H_ACTIVE) / 8)) bar_k = bar_k + 3'd1;
    end
    bar_rgb = 3'd7 - bar_k;

    hr_prod   = PROD_W'({hr_q, 2'b00});
    spo2_prod = {spo2_q, 3'b000};
    hr_len    = (COORD_W'(hr_prod) > H_MAX) ? H_MAX : COORD_W'(hr_prod);
    spo2_len  = (COORD_W'(spo2_prod) > H_MAX) ? H_MAX : COORD_W'(spo2_prod);
    hr_hit    = (row >= HR_TOP) && (row < HR_BOT) && (col < hr_len);
    spo2_hit  = (row >= SP_TOP) && (row < SP_BOT) && (col < spo2_len);

    in_range = (row < V_MAX) && (col < H_MAX);

    pix_rgb = 3'b000;
    if (in_range) begin
      unique case (mode_q)
        2'd0:    pix_rgb = idx_rgb;
        2'd1:    pix_rgb = bar_rgb;
        2'd2:    pix_rgb = (row[5] ^ col[5]) ? idx_rgb : 3'b000;
        default: pix_rgb = {hr_hit, 1'b0, spo2_hit};
      endcase
`ifdef FRAME_BORDER_EN
      if ((row == '0) || (row == V_MAX - COORD_W'(1)) ||
          (col == '0) || (col == H_MAX - COORD_W'(1)))
        pix_rgb = 3'b111;
`endif
    end

    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (bus.i_pix_req) begin
      red_d   = {COLOR_W{pix_rgb[2]}};
      green_d = {COLOR_W{pix_rgb[1]}};
      blue_d  = {COLOR_W{pix_rgb[0]}};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      color_idx_q <= 2'd0;
      mode_q      <= 2'd0;
      hr_sh_q     <= '0;
      spo2_sh_q   <= '0;
      hr_q        <= '0;
      spo2_q      <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      color_idx_q <= color_idx_d;
      mode_q      <= mode_d;
      hr_sh_q     <= hr_sh_d;
      spo2_sh_q   <= spo2_sh_d;
      hr_q        <= hr_d;
      spo2_q      <= spo2_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      pix_valid_q <= bus.i_pix_req;
    end
  end

  assign bus.o_red       = red_q;
  assign bus.o_green     = green_q;
  assign bus.o_blue      = blue_q;
  assign bus.o_pix_valid = pix_valid_q;
  assign bus.o_color_idx = color_idx_q;
endmodule

// File: tb/tb_frame_pattern_gen.sv
module tb_frame_pattern_gen;
  localparam int H = 800;
  localparam int V = 480;
  localparam int HOLD = 2;
`ifdef FRAME_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  frame_pattern_gen_if #(.COORD_W(16), .COLOR_W(8), .DATA_W(8)) bus ();

  frame_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(16), .COLOR_W(8),
    .HOLD_FRAMES(HOLD), .DATA_W(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model. Frame state changes only at frame start, and a
  // pixel is computed from the row and column with plain arithmetic.
  int m_cnt = 0, m_idx = 0, m_mode = 0;
  int m_hr_sh = 0, m_spo2_sh = 0, m_hr = 0, m_spo2 = 0;
  logic [23:0] e_rgb = 24'h0;
  logic        e_valid = 1'b0;

  function automatic logic [23:0] solid(input int idx);
    case (idx)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_pixel(input int row, input int col);
    logic [23:0] c;
    int k, v, hl, sl;
    c = 24'h0;
    if (row >= V || col >= H) return 24'h0;
    case (m_mode)
      0: c = solid(m_idx);
      1: begin
        k = 0;
        for (int j = 0; j < 8; j++)
          if (col >= (j * H) / 8 && col < ((j + 1) * H) / 8) k = j;
        v = 7 - k;
        c = {((v & 4) != 0) ? 8'hFF : 8'h00,
             ((v & 2) != 0) ? 8'hFF : 8'h00,
             ((v & 1) != 0) ? 8'hFF : 8'h00};
      end
      2: c = (((row / 32) % 2) != ((col / 32) % 2)) ? solid(m_idx) : 24'h0;
      default: begin
        hl = (m_hr * 4 < H) ? m_hr * 4 : H;
        sl = (m_spo2 * 8 < H) ? m_spo2 * 8 : H;
        if (row >= V / 4 && row < V / 4 + 40 && col < hl) c[23:16] = 8'hFF;
        if (row >= V / 2 && row < V / 2 + 40 && col < sl) c[7:0] = 8'hFF;
      end
    endcase
    if (BORDER && (row == 0 || row == V - 1 || col == 0 || col == H - 1))
      c = 24'hFFFFFF;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_mode = 0;
      m_hr_sh = 0; m_spo2_sh = 0; m_hr = 0; m_spo2 = 0;
      e_rgb = 24'h0; e_valid = 1'b0;
    end else begin
      e_valid = bus.i_pix_req;
      if (bus.i_pix_req)
        e_rgb = model_pixel(int'(bus.i_row_pixel), int'(bus.i_col_pixel));
      if (bus.i_alu_dv) begin
        m_hr_sh = int'(bus.i_hr);
        m_spo2_sh = int'(bus.i_spo2);
      end
      if (bus.i_frame_start) begin
        m_mode = int'(bus.i_mode);
        m_hr = m_hr_sh;
        m_spo2 = m_spo2_sh;
        if (m_cnt == HOLD - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 3;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", bus.o_pix_valid, e_valid);
    chk("cyc_rgb", {bus.o_red, bus.o_green, bus.o_blue}, e_rgb);
    chk("cyc_idx", bus.o_color_idx, m_idx);
  end

  // Directed helpers. Every one starts and ends 1 time unit after a rising edge.
  task automatic pix_lit(input string name, input int row, input int col, input logic [23:0] exp);
    bus.i_pix_req = 1'b1;
    bus.i_row_pixel = 16'(row);
    bus.i_col_pixel = 16'(col);
    @(posedge clk); #1;
    bus.i_pix_req = 1'b0;
    chk(name, {bus.o_red, bus.o_green, bus.o_blue}, exp);
    chk({name, "_valid"}, bus.o_pix_valid, 1);
  endtask

  task automatic fs_pulse();
    bus.i_frame_start = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_start = 1'b0;
  endtask

  task automatic dv_pulse(input int hr, input int spo2, input bit with_fs);
    bus.i_hr = 8'(hr);
    bus.i_spo2 = 8'(spo2);
    bus.i_alu_dv = 1'b1;
    bus.i_frame_start = with_fs;
    @(posedge clk); #1;
    bus.i_alu_dv = 1'b0;
    bus.i_frame_start = 1'b0;
  endtask

  int bar_cols[5] = '{0, 99, 100, 799, 800};
  logic [23:0] bar_exp[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'h000000};

  initial begin
    int row, col;
    bus.i_hr = '0; bus.i_spo2 = '0; bus.i_alu_dv = 1'b0; bus.i_mode = 2'd0;
    bus.i_frame_start = 1'b0; bus.i_pix_req = 1'b0;
    bus.i_row_pixel = '0; bus.i_col_pixel = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_rgb", {bus.o_red, bus.o_green, bus.o_blue}, 24'h0);
    chk("reset_valid", bus.o_pix_valid, 0);
    chk("reset_idx", bus.o_color_idx, 0);
    pix_lit("after_reset_red", 10, 10, 24'hFF0000);

    // Colour cycling with a hold of two frames.
    fs_pulse(); fs_pulse();
    chk("idx_after_2", bus.o_color_idx, 1);
    pix_lit("solid_green", 0, 5, BORDER ? 24'hFFFFFF : 24'h00FF00);
    fs_pulse(); fs_pulse();
    chk("idx_after_4", bus.o_color_idx, 2);
    pix_lit("solid_blue", 1, 5, 24'h0000FF);
    fs_pulse(); fs_pulse();
    chk("idx_after_6", bus.o_color_idx, 0);
    pix_lit("solid_red_again", 1, 5, 24'hFF0000);

    // Colour bars, requested back to back on row 0.
    bus.i_mode = 2'd1;
    fs_pulse();
    bus.i_row_pixel = '0;
    for (int i = 0; i < 5; i++) begin
      bus.i_pix_req = 1'b1;
      bus.i_col_pixel = 16'(bar_cols[i]);
      @(posedge clk); #1;
      chk("bars_rgb", {bus.o_red, bus.o_green, bus.o_blue},
          (BORDER && bar_cols[i] < H) ? 24'hFFFFFF : bar_exp[i]);
      chk("bars_valid", bus.o_pix_valid, 1);
    end
    bus.i_pix_req = 1'b0;

    // Vitals.
    dv_pulse(60, 98, 1'b0);
    bus.i_mode = 2'd3;
    fs_pulse();
    pix_lit("hr_last", 120, 239, 24'hFF0000);
    pix_lit("hr_past", 120, 240, 24'h000000);
    pix_lit("spo2_last", 240, 783, 24'h0000FF);
    pix_lit("spo2_past", 240, 784, 24'h000000);
    dv_pulse(255, 98, 1'b1);
    pix_lit("hr_saturated", 120, 798, 24'hFF0000);
    pix_lit("hr_sat_edge", 120, 799, BORDER ? 24'hFFFFFF : 24'hFF0000);
    pix_lit("border_top", 0, 400, BORDER ? 24'hFFFFFF : 24'h000000);
    pix_lit("border_bot", 479, 0, BORDER ? 24'hFFFFFF : 24'h000000);

    // Mode and vitals changes mid-frame must wait for the next frame.
    bus.i_mode = 2'd0;
    fs_pulse();
    bus.i_mode = 2'd2;
    dv_pulse(50, 98, 1'b0);
    pix_lit("midframe_hold", 5, 32, 24'h0000FF);
    fs_pulse();
    pix_lit("checker_on", 0, 32, BORDER ? 24'hFFFFFF : 24'h0000FF);
    pix_lit("checker_off", 32, 32, 24'h000000);
    bus.i_mode = 2'd3;
    dv_pulse(50, 0, 1'b1);
    pix_lit("coinc_hr_last", 120, 199, 24'hFF0000);
    pix_lit("coinc_hr_past", 120, 200, 24'h000000);
    pix_lit("spo2_zero", 240, 5, 24'h000000);

    // Reset asserted while a request is outstanding.
    bus.i_pix_req = 1'b1;
    bus.i_row_pixel = 16'd120;
    bus.i_col_pixel = 16'd10;
    @(posedge clk); #1;
    chk("pre_rst_red", {bus.o_red, bus.o_green, bus.o_blue}, 24'hFF0000);
    rst = 1'b1;
    #1;
    chk("rst_async_rgb", {bus.o_red, bus.o_green, bus.o_blue}, 24'h0);
    chk("rst_async_valid", bus.o_pix_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_pix_req = 1'b0;
    pix_lit("post_rst_red", 10, 10, 24'hFF0000);
    chk("post_rst_idx", bus.o_color_idx, 0);

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      bus.i_pix_req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: row = $urandom_range(V / 4 - 2, V / 4 + 42);
        1: row = $urandom_range(V / 2 - 2, V / 2 + 42);
        default: row = $urandom_range(0, V + 10);
      endcase
      col = $urandom_range(0, H + 10);
      bus.i_row_pixel = 16'(row);
      bus.i_col_pixel = 16'(col);
      bus.i_frame_start = ($urandom_range(0, 39) == 0);
      bus.i_alu_dv = ($urandom_range(0, 29) == 0);
      bus.i_hr = 8'($urandom_range(0, 255));
      bus.i_spo2 = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 49) == 0) bus.i_mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 999) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.i_pix_req = 1'b0;
    bus.i_frame_start = 1'b0;
    bus.i_alu_dv = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
